// File: rtl/mem_rr_arbiter_pkg.sv
// Shared memory-request types and arbiter FSM encoding for the round-robin
// memory arbiter and its id queue.
package mem_rr_arbiter_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int DEFAULT_CNT = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mresp;

  typedef logic [$clog2(DEFAULT_CNT)-1:0] master_idx;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_rr_arbiter_queue.sv
// Circular id queue; FALLTHROUGH=1 shows the head entry combinationally,
// FALLTHROUGH=0 registers the entry on each pop.
module mem_rr_arbiter_queue #(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 2,
  parameter bit FALLTHROUGH = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; only pointers and count define which entries
  // are live, so clearing the array would buy nothing but reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  if (FALLTHROUGH) begin : g_fwft
    assign pop_data = mem[rd_ptr];
  end else begin : g_reg
    logic [WIDTH-1:0] pop_q;
    always_ff @(posedge clk) begin
      if (!rst || flush) pop_q <= '0;
      else if (do_pop)   pop_q <= mem[rd_ptr];
    end
    assign pop_data = pop_q;
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among CNT masters;
// an id queue records grant order so responses route back to their owner.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int CNT             = 4,
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  mreq  [CNT-1:0]      master_req_data,
  input  logic [CNT-1:0]      master_req_valid,
  output logic [CNT-1:0]      master_req_ready,
  output mresp [CNT-1:0]      master_resp_data,
  output logic [CNT-1:0]      master_resp_valid,
  input  logic [CNT-1:0]      master_resp_ready,
  output mreq                 slave_req_data,
  output logic                slave_req_valid,
  input  logic                slave_req_ready,
  input  mresp                slave_resp_data,
  input  logic                slave_resp_valid,
  output logic                slave_resp_ready,
  output logic                busy
);

  localparam int IW = $clog2(CNT);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(QUEUE_DEPTH + 1);

  arb_state_e     state;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  locked_idx;
  logic [IW-1:0]  rr_idx;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  head;
  logic           rr_found;
  logic           grant_valid;
  logic           req_hs;
  logic           resp_hs;
  logic           q_empty;
  logic           q_full;
  logic [QW-1:0]  q_count;
  logic [OW-1:0]  outstanding [CNT];
  logic [CNT-1:0] eligible;
  logic [CNT-1:0] out_inc;
  logic [CNT-1:0] out_dec;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and infers a latch.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < CNT; i++)
      eligible[i] = master_req_valid[i] && (outstanding[i] < OW'(MAX_OUTSTANDING));
  end

  // Scan from the farthest candidate down so the nearest one after
  // last_grant is the one left standing.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant;
    for (int k = CNT; k >= 1; k--) begin
      if (eligible[(int'(last_grant) + k) % CNT]) begin
        rr_found = 1'b1;
        rr_idx   = IW'((int'(last_grant) + k) % CNT);
      end
    end
  end

  assign grant           = (state == ARB_LOCKED) ? locked_idx : rr_idx;
  assign grant_valid     = (state == ARB_LOCKED) || rr_found;
  assign slave_req_valid = rst && grant_valid && !q_full;
  assign slave_req_data  = master_req_data[grant];
  assign req_hs          = slave_req_valid && slave_req_ready;

  assign slave_resp_ready = rst && !q_empty && master_resp_ready[head];
  assign resp_hs          = slave_resp_valid && slave_resp_ready;
  assign busy             = rst && (q_count != '0);

  always_comb begin
    master_req_ready  = '0;
    master_resp_valid = '0;
    out_inc           = '0;
    out_dec           = '0;
    for (int i = 0; i < CNT; i++) begin
      master_req_ready[i]  = req_hs && (grant == IW'(i));
      master_resp_valid[i] = rst && slave_resp_valid && !q_empty && (head == IW'(i));
      master_resp_data[i]  = slave_resp_data;
      out_inc[i]           = req_hs && (grant == IW'(i));
      out_dec[i]           = resp_hs && (head == IW'(i));
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      last_grant <= IW'(CNT - 1);
      locked_idx <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (slave_req_valid && !slave_req_ready) begin
            state      <= ARB_LOCKED;
            locked_idx <= grant;
          end
        end
        ARB_LOCKED: begin
          if (req_hs) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
      if (req_hs) last_grant <= grant;
    end
  end

  // A grant only reaches a master below its limit, and a decrement only
  // happens for an id still in the queue, so the counters stay in range.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CNT; i++) begin
      if (!rst)                        outstanding[i] <= '0;
      else if (out_inc[i] && !out_dec[i]) outstanding[i] <= outstanding[i] + OW'(1);
      else if (out_dec[i] && !out_inc[i]) outstanding[i] <= outstanding[i] - OW'(1);
    end
  end

  mem_rr_arbiter_queue #(
    .DEPTH       (QUEUE_DEPTH),
    .WIDTH       (IW),
    .FALLTHROUGH (1'b1)
  ) u_id_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_hs),
    .push_data (grant),
    .pop       (resp_hs),
    .pop_data  (head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomized bench for mem_rr_arbiter: a transaction-level model (grant
// order list, per-master counts, in-order memory) predicts every output.
module tb_mem_rr_arbiter;
  import mem_rr_arbiter_pkg::*;

  localparam int CNT = 4;
  localparam int QD  = 8;
  localparam int MO  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  mreq  [CNT-1:0] master_req_data;
  logic [CNT-1:0] master_req_valid;
  logic [CNT-1:0] master_req_ready;
  mresp [CNT-1:0] master_resp_data;
  logic [CNT-1:0] master_resp_valid;
  logic [CNT-1:0] master_resp_ready;
  mreq            slave_req_data;
  logic           slave_req_valid;
  logic           slave_req_ready;
  mresp           slave_resp_data;
  logic           slave_resp_valid;
  logic           slave_resp_ready;
  logic           busy;

  always #5 clk = ~clk;

  mem_rr_arbiter #(
    .CNT             (CNT),
    .QUEUE_DEPTH     (QD),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .master_req_data   (master_req_data),
    .master_req_valid  (master_req_valid),
    .master_req_ready  (master_req_ready),
    .master_resp_data  (master_resp_data),
    .master_resp_valid (master_resp_valid),
    .master_resp_ready (master_resp_ready),
    .slave_req_data    (slave_req_data),
    .slave_req_valid   (slave_req_valid),
    .slave_req_ready   (slave_req_ready),
    .slave_resp_data   (slave_resp_data),
    .slave_resp_valid  (slave_resp_valid),
    .slave_resp_ready  (slave_resp_ready),
    .busy              (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: order of accepted requests, per-master counts,
  // and an in-order memory with a fixed response latency.
  typedef struct {
    mresp r;
    int   due;
  } mem_ent_t;

  int       last_g;
  int       held;
  int       outst [CNT];
  int       ids [$];
  mem_ent_t memq [$];
  mresp     sb [CNT][$];

  logic [CNT-1:0] mv;
  mreq            md [CNT];
  logic [CNT-1:0] mask;
  int             p_valid, p_sready, p_mready, lat;
  bit             resp_en;

  function automatic mreq rand_req();
    mreq q;
    q.we    = 1'($urandom);
    q.addr  = 16'($urandom);
    q.wdata = $urandom;
    return q;
  endfunction

  function automatic mresp mem_resp(input mreq q);
    mresp r;
    r.rdata = q.wdata ^ {q.addr, q.addr};
    r.err   = q.we & q.addr[0];
    return r;
  endfunction

  task automatic model_reset();
    held   = -1;
    last_g = CNT - 1;
    for (int i = 0; i < CNT; i++) begin
      outst[i] = 0;
      sb[i].delete();
    end
    ids.delete();
    memq.delete();
  endtask

  task automatic cycle_step(input bit rst_val);
    int             g;
    int             j;
    int             head;
    bit             srv;
    bit             e_svalid, e_req_hs, e_sready, e_resp_hs, e_busy;
    logic [CNT-1:0] e_mready, e_mrvalid;
    mresp           exp_r;
    mresp           junk;

    @(posedge clk);
    #1;
    rst = rst_val;
    for (int i = 0; i < CNT; i++) begin
      master_req_valid[i]  = mv[i];
      master_req_data[i]   = md[i];
      master_resp_ready[i] = ($urandom_range(99) < p_mready);
    end
    slave_req_ready = ($urandom_range(99) < p_sready);
    srv = resp_en && (memq.size() > 0) && (memq[0].due <= cyc);
    slave_resp_valid = srv;
    junk.rdata = $urandom;
    junk.err   = 1'($urandom);
    slave_resp_data = srv ? memq[0].r : junk;
    #1;

    // Who should be offered to memory this cycle.
    g = -1;
    if (held >= 0) g = held;
    else begin
      for (int k = 1; k <= CNT; k++) begin
        j = (last_g + k) % CNT;
        if (g < 0 && mv[j] && outst[j] < MO) g = j;
      end
    end
    e_svalid = rst_val && (g >= 0) && (ids.size() < QD);
    e_req_hs = e_svalid && slave_req_ready;
    e_mready = '0;
    if (e_req_hs) e_mready[g] = 1'b1;

    head      = (ids.size() > 0) ? ids[0] : -1;
    e_sready  = rst_val && (head >= 0) && master_resp_ready[head];
    e_mrvalid = '0;
    if (rst_val && srv && head >= 0) e_mrvalid[head] = 1'b1;
    e_resp_hs = srv && e_sready;
    e_busy    = rst_val && (ids.size() > 0);

    check("slave_req_valid", 64'(slave_req_valid), 64'(e_svalid));
    check("master_req_ready", 64'(master_req_ready), 64'(e_mready));
    if (e_svalid) check("slave_req_data", 64'(slave_req_data), 64'(md[g]));
    check("slave_resp_ready", 64'(slave_resp_ready), 64'(e_sready));
    check("master_resp_valid", 64'(master_resp_valid), 64'(e_mrvalid));
    check("busy", 64'(busy), 64'(e_busy));
    if (e_resp_hs) begin
      check("scoreboard_nonempty", 64'(sb[head].size() > 0), 64'(1));
      if (sb[head].size() > 0) begin
        exp_r = sb[head].pop_front();
        check("master_resp_data", 64'(master_resp_data[head]), 64'(exp_r));
      end
    end

    if (!rst_val) model_reset();
    else begin
      if (e_resp_hs) begin
        void'(ids.pop_front());
        void'(memq.pop_front());
        outst[head]--;
      end
      if (e_req_hs) begin
        ids.push_back(g);
        outst[g]++;
        last_g = g;
        held   = -1;
        memq.push_back('{r: mem_resp(md[g]), due: cyc + lat});
        sb[g].push_back(mem_resp(md[g]));
      end else if (e_svalid) begin
        held = g;
      end
    end

    // Masters hold valid and data until accepted, then may issue again.
    for (int i = 0; i < CNT; i++) begin
      if (mv[i] && e_mready[i]) mv[i] = 1'b0;
      if (!mv[i] && mask[i] && ($urandom_range(99) < p_valid)) begin
        mv[i] = 1'b1;
        md[i] = rand_req();
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b1);
  endtask

  initial begin
    model_reset();
    mv       = '0;
    mask     = '1;
    p_valid  = 100;
    p_sready = 100;
    p_mready = 100;
    lat      = 3;
    resp_en  = 1'b1;
    for (int i = 0; i < CNT; i++) md[i] = rand_req();
    master_req_valid  = '0;
    master_req_data   = '0;
    master_resp_ready = '0;
    slave_req_ready   = 1'b0;
    slave_resp_valid  = 1'b0;
    slave_resp_data   = '0;

    for (int i = 0; i < 3; i++) cycle_step(1'b0);

    // All masters busy, memory always ready, 3-cycle responses.
    run(40);

    // Mixed random traffic.
    p_valid = 40; p_sready = 60; p_mready = 70; lat = 2;
    run(300);

    // Heavy memory back-pressure exercises the locked grant.
    p_valid = 60; p_sready = 15; lat = 1;
    run(200);

    // Drain, then master 1 alone with responses withheld and released.
    mask = '0; p_sready = 100; p_mready = 100;
    run(60);
    mask = 4'b0010; p_valid = 100; resp_en = 1'b0;
    run(10);
    resp_en = 1'b1; lat = 4;
    run(20);

    // Every master busy with responses withheld fills the id queue.
    mask = '1; resp_en = 1'b0;
    run(20);
    resp_en = 1'b1; lat = 1;
    run(40);

    // Slow response consumers.
    p_mready = 30; p_valid = 70; p_sready = 80; lat = 3;
    run(200);

    // Reset pulse with a few requests in flight.
    p_mready = 100; p_sready = 100; p_valid = 100; resp_en = 1'b0;
    for (int n = 0; n < 20 && ids.size() < 3; n++) cycle_step(1'b1);
    cycle_step(1'b0);
    resp_en = 1'b1;
    run(30);

    // Random knobs with occasional resets.
    for (int blk = 0; blk < 8; blk++) begin
      p_valid  = $urandom_range(100, 10);
      p_sready = $urandom_range(100, 10);
      p_mready = $urandom_range(100, 10);
      lat      = $urandom_range(6, 1);
      mask     = 4'($urandom_range(15, 1));
      for (int i = 0; i < 50; i++) cycle_step($urandom_range(99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
